i2c_target_regs: RTL
====================

# i2c_target_regs

I2C target (responder) with an internal byte-wide register bank: the peer to the team's I2C master on the same two-wire bus. It oversamples SCL/SDA on the system clock and detects START/STOP. It ACKs its own 7-bit address, takes a register pointer plus write data from the master, and returns register contents on reads with pointer auto-increment. A host-side port lets local logic preload and read the bank.

## Interface
- `TARGET_ADDR`, default 7'h42: 7-bit bus address this block responds to.
- `NUM_REGS`, default 8: register count, power of 2. Pointer width `PW = log2(NUM_REGS)`.
- `clk`  in  1: system clock. Must be ≥ 8× SCL frequency; SCL high and low phases ≥ 4 clk each.
- `rst_n`  in  1: asynchronous, active-low reset.
- `scl_in`  in  1: bus SCL, asynchronous.
- `sda_in`  in  1: bus SDA, asynchronous.
- `sda_oe`  out  1: 1 = pull SDA low. The pad is open-drain; this block never drives SDA high.
- `host_we`  in  1: host write strobe.
- `host_addr`  in  PW: host register index, used for both read and write.
- `host_wdata`  in  8: host write data.
- `host_rdata`  out  8: combinational read of `reg[host_addr]`.
- `wr_strobe`  out  1: one-cycle pulse when a bus write lands in a register.
- `wr_index`  out  PW: index written. Valid while `wr_strobe` is high.
- `busy`  out  1: high from an address match until STOP, or until a START that does not match.

## Operation
- **Input sampling**
  - Two-flop synchronizers on `scl_in` and `sda_in`, followed by a delayed copy of each for edge detection.
  - START = synced SDA 1→0 while synced SCL = 1.
  - STOP = synced SDA 0→1 while synced SCL = 1.
  - Data bits are sampled on the synced SCL rising edge. `sda_oe` changes only on the synced SCL falling edge, except at START, STOP, and reset.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- **Global transitions**
  - START in any state → ADDR: bit count cleared, `sda_oe` = 0. This covers repeated START.
  - STOP in any state → IDLE: `sda_oe` = 0, `busy` = 0. The pointer is retained.
- **ADDR:** shift in 8 bits, MSB first.
  - Bits [7:1] == TARGET_ADDR → ADDR_ACK, `busy` = 1, with the R/W bit latched.
  - Otherwise → WAIT_STOP.
- **ADDR_ACK**
  - On the next SCL fall: `sda_oe` = 1.
  - On the following SCL fall:
    - Write: `sda_oe` = 0, then → PTR if this is the first write byte of the transaction, else → WR_DATA.
    - Read: drive bit 7 of `reg[ptr]` (`sda_oe` = ~bit), then → RD_DATA.
- **PTR:** 8 bits received; `ptr` ← `byte[PW-1:0]` (upper bits ignored). Then ACK the same way as the address and continue in WR_DATA.
- **WR_DATA:** 8 bits received; `reg[ptr]` ← byte, `wr_strobe` pulses with `wr_index` = `ptr`, and `ptr` ← `ptr`+1 mod NUM_REGS. Then WR_ACK (ACK) → WR_DATA.
- **RD_DATA**
  - Bits 6..0 are presented on successive SCL falls.
  - After the 8th bit, release SDA on the SCL fall → RD_ACK, with `ptr` ← `ptr`+1 mod NUM_REGS.
- **RD_ACK:** sample the master bit on SCL rise.
  - 0 (ACK): load `reg[ptr]` and drive its MSB on the next fall → RD_DATA.
  - 1 (NACK) → WAIT_STOP.
- **WAIT_STOP:** `sda_oe` = 0; ignore everything until START or STOP.
- **Register writes**
  - Host write updates `reg[host_addr]` in the same cycle.
  - If a host write and a bus write hit the same index in the same cycle, the bus write wins.
  - The byte shifted out is captured when loaded; later host writes do not alter a byte already in flight.

## Timing
- **Reset values:** `sda_oe` = 0, `busy` = 0, `wr_strobe` = 0, `wr_index` = 0, all registers = 0, `ptr` = 0, state IDLE.
- **Reset mid-transaction:** all outputs go to reset values immediately. There is no attempt to finish a byte.
- **Detection latency:** 3 clk from a pad edge to START/STOP/edge detection (2 synchronizer stages plus 1 edge register). `sda_oe` updates 1 clk after the detected SCL fall, giving ≥ 3 clk of hold after the physical SCL fall.
- **Write strobe:** `wr_strobe` is asserted 1 clk after the detected rising edge of the 8th data bit.
- **Pointer wrap:** modulo NUM_REGS. Index 7 + 1 → 0 at the default.
- **Clock stretching:** not implemented.
- **General call (address 0):** not ACKed.

## Test plan
- Write 0x84, 0x02, 0xA5, 0x5A, STOP → ACK on all 4 bytes; reg2 = 0xA5, reg3 = 0x5A; `wr_strobe` pulses twice with `wr_index` = 2, then 3; `busy` ends 0.
- Address 0x90 followed by 0x11 → `sda_oe` never asserts and no register changes. A following 0x84 transaction after START is ACKed.
- Preload reg7 = 0x3C and reg0 = 0xC3 via the host. Sequence: write 0x84, 0x07; repeated START; 0x85; read two bytes (ACK, then NACK); STOP → bus reads 0x3C then 0xC3 (wrap), and `ptr` = 1 at the end.
- Write 0x84, 0x07, 0x11, 0x22 → reg7 = 0x11 and reg0 = 0x22 (pointer wrap).
- Assert reset during RD_DATA while `sda_oe` = 1 → `sda_oe` = 0 in the same cycle, registers are cleared, and a new START/0x84 is ACKed.
- Host write of 0xFF to reg4 in the same clk as a bus write of 0x55 to reg4 → reg4 = 0x55; `host_rdata` (host_addr = 4) = 0x55.

Source files
------------

// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register bank: oversampled SCL/SDA, 7-bit address match,
// register pointer with auto-increment, and a host port for local preload/readback.
module i2c_target_regs #(
    parameter logic [6:0]  TARGET_ADDR = 7'h42,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned PW          = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe,
    input  logic          host_we,
    input  logic [PW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata,
    output logic          wr_strobe,
    output logic [PW-1:0] wr_index,
    output logic          busy
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_t;

    // Synchronizers reset to the idle-bus level so release of reset creates no false edges.
    logic [1:0] scl_sync, sda_sync;
    logic       scl_d, sda_d;
    logic       scl_s, sda_s;

    // NOTE: sequential state is assigned with non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s = scl_sync[1];
    assign sda_s = sda_sync[1];

    logic start_det, stop_det, scl_rise, scl_fall;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;

    logic [7:0]    regs [NUM_REGS];

    state_t        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [6:0]    shift_q, shift_d;
    logic [6:0]    tx_q, tx_d;
    logic          rw_q, rw_d;
    logic          ack_phase_q, ack_phase_d;
    logic          ptr_seen_q, ptr_seen_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic [PW-1:0] wr_index_q, wr_index_d;
    logic          bus_we;
    logic [7:0]    rx_byte;
    logic [7:0]    rd_byte;

    // The byte completes combinationally with the bit being sampled on this SCL rise.
    assign rx_byte = {shift_q, sda_s};
    assign rd_byte = regs[ptr_q];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        rw_d        = rw_q;
        ack_phase_d = ack_phase_q;
        ptr_seen_d  = ptr_seen_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_index_d  = wr_index_q;
        bus_we      = 1'b0;

        if (stop_det) begin
            state_d    = IDLE;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            ptr_seen_d = 1'b0;
        end else if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;

                ADDR: begin
                    if (scl_rise) begin
                        shift_d = rx_byte[6:0];
                        if (bit_cnt_q == 4'd7) begin
                            if (rx_byte[7:1] == TARGET_ADDR && rx_byte[7:1] != 7'd0) begin
                                state_d     = ADDR_ACK;
                                busy_d      = 1'b1;
                                rw_d        = rx_byte[0];
                                ack_phase_d = 1'b0;
                            end else begin
                                state_d = WAIT_STOP;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end

                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_oe_d    = 1'b1;
                            ack_phase_d = 1'b1;
                        end else begin
                            ack_phase_d = 1'b0;
                            bit_cnt_d   = 4'd0;
                            if (rw_q) begin
                                tx_d      = rd_byte[6:0];
                                sda_oe_d  = ~rd_byte[7];
                                bit_cnt_d = 4'd1;
                                state_d   = RD_DATA;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = ptr_seen_q ? WR_DATA : PTR;
                            end
                        end
                    end
                end

                PTR: begin
                    if (scl_rise) begin
                        shift_d = rx_byte[6:0];
                        if (bit_cnt_q == 4'd7) begin
                            ptr_d       = rx_byte[PW-1:0];
                            ptr_seen_d  = 1'b1;
                            ack_phase_d = 1'b0;
                            state_d     = WR_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end

                WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = rx_byte[6:0];
                        if (bit_cnt_q == 4'd7) begin
                            bus_we      = 1'b1;
                            wr_strobe_d = 1'b1;
                            wr_index_d  = ptr_q;
                            ptr_d       = ptr_q + PW'(1);
                            ack_phase_d = 1'b0;
                            state_d     = WR_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end

                WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_oe_d    = 1'b1;
                            ack_phase_d = 1'b1;
                        end else begin
                            sda_oe_d    = 1'b0;
                            ack_phase_d = 1'b0;
                            bit_cnt_d   = 4'd0;
                            state_d     = WR_DATA;
                        end
                    end
                end

                // bit_cnt counts bits already on the bus; the fall after bit 0 releases SDA.
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d    = 1'b0;
                            ptr_d       = ptr_q + PW'(1);
                            ack_phase_d = 1'b0;
                            state_d     = RD_ACK;
                        end else begin
                            sda_oe_d  = ~tx_q[6];
                            tx_d      = {tx_q[5:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end

                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_d = WAIT_STOP;
                        end else begin
                            ack_phase_d = 1'b1;
                        end
                    end else if (scl_fall && ack_phase_q) begin
                        tx_d        = rd_byte[6:0];
                        sda_oe_d    = ~rd_byte[7];
                        bit_cnt_d   = 4'd1;
                        ack_phase_d = 1'b0;
                        state_d     = RD_DATA;
                    end
                end

                WAIT_STOP: sda_oe_d = 1'b0;

                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 7'd0;
            tx_q        <= 7'd0;
            rw_q        <= 1'b0;
            ack_phase_q <= 1'b0;
            ptr_seen_q  <= 1'b0;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            ack_phase_q <= ack_phase_d;
            ptr_seen_q  <= ptr_seen_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_index_q  <= wr_index_d;
        end
    end

    // NOTE: the bank is small and must read back as zero after reset, so it is reset explicitly.
    // The bus write is assigned last so it wins a same-index collision with the host.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'd0;
            end
        end else begin
            if (host_we) begin
                regs[host_addr] <= host_wdata;
            end
            if (bus_we) begin
                regs[ptr_q] <= rx_byte;
            end
        end
    end

    assign sda_oe     = sda_oe_q;
    assign busy       = busy_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_index   = wr_index_q;
    assign host_rdata = regs[host_addr];

endmodule
